// File: rtl/pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
// Level geometry is derived here so the tree and its bench-free users agree on it.
package pipe_pkg;

  // Smallest r such that 2**r >= n.
  function automatic int unsigned clog2_ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Number of register levels for an n_in-operand tree.
  function automatic int unsigned tree_lvl(input int unsigned n_in);
    return clog2_ceil(n_in);
  endfunction

  // Width of the final sum.
  function automatic int unsigned tree_ow(input int unsigned w, input int unsigned n_in);
    return w + clog2_ceil(n_in);
  endfunction

  // Partial sums present at level j (level 0 is the raw operand set).
  function automatic int unsigned lvl_cnt(input int unsigned n_in, input int unsigned j);
    return (n_in + (32'd1 << j) - 32'd1) >> j;
  endfunction

  // Bit offset of level j inside the flattened tree vector; each level j
  // entry is w+j bits wide, so level offsets accumulate per-level sizes.
  function automatic int unsigned lvl_off(input int unsigned n_in, input int unsigned w,
                                          input int unsigned j);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < j; k++) off += lvl_cnt(n_in, k) * (w + k);
    return off;
  endfunction

  localparam int unsigned DEF_N_IN = 4;
  localparam int unsigned DEF_W    = 10;
  localparam int unsigned DEF_LVL  = tree_lvl(DEF_N_IN);
  localparam int unsigned DEF_OW   = tree_ow(DEF_W, DEF_N_IN);

endpackage

// File: rtl/pipe_add_level.sv
// One registered level of the adder tree: pairs adjacent operands, widens each
// by one bit and registers the sums. An odd trailing operand is paired with zero.
module pipe_add_level #(
  parameter int unsigned N_OP   = 2,
  parameter int unsigned IW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [N_OP*IW-1:0]                  in_data,
  output logic [((N_OP+1)/2)*(IW+1)-1:0]      out_data
);

  localparam int unsigned N_OUT = (N_OP + 1) / 2;

  for (genvar i = 0; i < N_OUT; i++) begin : gen_add
    logic [IW-1:0] op_a;
    logic [IW-1:0] op_b;
    logic [IW:0]   ext_a;
    logic [IW:0]   ext_b;
    logic [IW:0]   sum_d;
    logic [IW:0]   sum_q;

    assign op_a = in_data[2*i*IW +: IW];

    if (2*i + 1 < N_OP) begin : gen_pair
      assign op_b = in_data[(2*i+1)*IW +: IW];
    end else begin : gen_pad
      assign op_b = '0;
    end

    assign ext_a = {SIGNED & op_a[IW-1], op_a};
    assign ext_b = {SIGNED & op_b[IW-1], op_b};
    assign sum_d = ext_a + ext_b;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  sum_q <= '0;
      else if (en) sum_q <= sum_d;
    end

    assign out_data[i*(IW+1) +: IW+1] = sum_q;
  end

endmodule

// File: rtl/pipe_add_tree.sv
// Pipelined binary adder tree with a single global advance enable and
// valid/ready handshake on both sides; one result per cycle when unstalled.
module pipe_add_tree
  import pipe_pkg::*;
#(
  parameter int unsigned N_IN   = DEF_N_IN,
  parameter int unsigned W      = DEF_W,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_IN*W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [tree_ow(W, N_IN)-1:0]   out_sum,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned LVL       = tree_lvl(N_IN);
  localparam int unsigned OW        = tree_ow(W, N_IN);
  localparam int unsigned TREE_BITS = lvl_off(N_IN, W, LVL + 1);

  // All levels flattened into one vector: level 0 is the input operands,
  // level LVL is the single final sum.
  logic [TREE_BITS-1:0] tree;
  logic [LVL-1:0]       vld_q;
  logic                 adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign tree[N_IN*W-1:0] = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int unsigned k = 1; k < LVL; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  for (genvar j = 0; j < LVL; j++) begin : gen_lvl
    localparam int unsigned NI = lvl_cnt(N_IN, j);
    localparam int unsigned NO = lvl_cnt(N_IN, j + 1);
    localparam int unsigned IW = W + j;
    localparam int unsigned OI = lvl_off(N_IN, W, j);
    localparam int unsigned OO = lvl_off(N_IN, W, j + 1);

    logic v_in;

    if (j == 0) begin : gen_src_in
      assign v_in = in_valid;
    end else begin : gen_src_lvl
      assign v_in = vld_q[j-1];
    end

    // Data only loads alongside a valid token, so bubbles leave the
    // registers untouched and out_sum stays 0 until the first real result.
    pipe_add_level #(
      .N_OP   (NI),
      .IW     (IW),
      .SIGNED (SIGNED)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv & v_in),
      .in_data  (tree[OI +: NI*IW]),
      .out_data (tree[OO +: NO*(IW+1)])
    );
  end

  assign out_valid = vld_q[LVL-1];
  assign out_sum   = tree[lvl_off(N_IN, W, LVL) +: OW];

endmodule

// File: doc/pipe_add_tree.md
PIPE_ADD_TREE -- requirements
Module: pipe_add_tree

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of operands summed per transaction; legal range is 2..16.
REQ-002 The block SHALL have parameter W, default 10, meaning the width of each operand in bits; legal range is 1..32.
REQ-003 The block SHALL have parameter SIGNED, default 0: 0 treats operands as unsigned, 1 treats them as two's-complement.
REQ-004 The block SHALL define derived constants LVL = ceil(log2(N_IN)) and OW = W + LVL; these are not overridable.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  N_IN*W  packed operands; operand k SHALL occupy bits [k*W+W-1 : k*W].
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  the block accepts in_data this cycle.
REQ-010 out_sum  output  OW  sum of one accepted operand set.
REQ-011 out_valid  output  1  out_sum is valid.
REQ-012 out_ready  input  1  the downstream stage accepts out_sum this cycle.

Function
REQ-013 The block SHALL be a binary adder tree with LVL register levels; level j SHALL hold ceil(N_IN/2^j) partial sums, each W+j bits wide.
REQ-014 When N_IN is not a power of two, missing operand slots SHALL be treated as zero at level 0.
REQ-015 Each addition SHALL widen its operands by one bit, sign-extending when SIGNED=1 and zero-extending when SIGNED=0, so no overflow is possible.
REQ-016 A valid bit SHALL accompany each level; out_valid SHALL be the valid bit of the last level.
REQ-017 The global advance enable SHALL be adv = ~out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-018 A transfer SHALL occur when in_valid & in_ready; when adv=1, every level SHALL load from its predecessor, with level 1 loading the new valid bit in_valid.
REQ-019 When adv=0, all data and valid registers SHALL hold.
REQ-020 Latency SHALL be exactly LVL cycles from an accepted input to out_valid, with no stalls.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-022 Bubbles (stage valid=0) SHALL propagate and SHALL NOT be compressed.
REQ-023 out_sum and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Data registers whose valid bit is 0 MAY hold any value; out_sum SHALL be 0 after reset until the first valid result.
REQ-025 Results SHALL leave in strict acceptance order; transactions SHALL NOT be dropped or duplicated.
REQ-026 When N_IN=2, LVL=1 and the block SHALL be a single registered adder with the same handshake.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously clear all valid bits, all partial sums and out_sum to 0.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions with no partial output.
REQ-030 Reset deassertion SHALL take effect at the next rising edge; no transaction SHALL be accepted on the edge where rst_n is low.

Structure
REQ-031 The helper function computing ceil(log2) SHALL live in the shared package pipe_pkg, along with the derived constants for LVL and OW.
REQ-032 One level of the tree SHALL be a sub-module pipe_add_level, parametrised by operand count, input width and SIGNED, containing that level's adders and registers.
REQ-033 pipe_add_tree SHALL instantiate LVL copies of pipe_add_level through a generate loop and SHALL own the valid chain and adv.

Verification
REQ-034 With N_IN=3, W=10, SIGNED=0, operands {1023,1023,1023} with in_valid pulsed once and out_ready=1 -> out_sum=3069 (12 bits), out_valid high on exactly one cycle, 2 cycles after acceptance.
REQ-035 With N_IN=4, W=8, SIGNED=1, operands {-128,-128,-128,-128} -> out_sum=-512 (10-bit 0x200); with operands {127,-1,0,5} -> out_sum=131.
REQ-036 Streaming operands 0..15 into every lane (N_IN=4) with out_ready held low for cycles 5..8 -> in_ready low for cycles 5..8, out_sum held stable, and all 16 sums (4k) delivered in order with none lost.
REQ-037 Alternating in_valid=1/0 with out_ready=1 -> out_valid alternates with the same pattern delayed by LVL cycles.
REQ-038 Reset asserted while 2 transactions are in flight -> out_valid=0 and out_sum=0 immediately; after release, a new input {1,2,3,4} produces 10 as the first output.
REQ-039 With N_IN=2, W=1, operands {1,1} -> out_sum=2 after 1 cycle.
